// File: rtl/ram_clear_ctrl.sv
// ram_clear_ctrl: sweeps the whole main RAM with a fill pattern after reset or
// on request, then passes the core's RAM port straight through to the array.
//
// Ports:
//   clk_sys  system clock
//   reset    asynchronous active-high reset; restarts a full sweep on release
//   start    synchronous request to (re)start a sweep from address 0
//   mode     fill pattern: 0 constant, 1 stripe, 2 address low bits, 3 zero
//   ce       sweep advance enable; one RAM write per cycle with ce=1
//   cpu_*    core RAM port (address, write data, write enable, chip select)
//   mem_*    RAM array port; mem_we is already qualified with chip select
//   busy     high while a sweep is armed or running (core must be held)
//   done     one-cycle pulse in the first cycle after a sweep completes
//
// The RAM array outputs are combinational from the state registers (and from
// the core port in IDLE) so that a write lands in the same cycle it is
// presented; busy is decoded from the state register.

module ram_clear_ctrl #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] FILL_VALUE  = '1,
  // Address bit selecting the stripe polarity; must be below ADDR_W.
  parameter int unsigned       STRIPE_LOG2 = 7
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              ce,
  input  logic [ADDR_W-1:0] cpu_ad,
  input  logic [DATA_W-1:0] cpu_d,
  input  logic              cpu_we,
  input  logic              cpu_cs,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       CNT_W    = ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] MODE_CONST  = 2'd0;
  localparam logic [1:0] MODE_STRIPE = 2'd1;
  localparam logic [1:0] MODE_ADDR   = 2'd2;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;

  // Fill pattern for one sweep location.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0]       m,
                                            input logic [CNT_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = '0;
    case (m)
      MODE_CONST:  p = FILL_VALUE;
      MODE_STRIPE: p = a[STRIPE_LOG2] ? ~FILL_VALUE : FILL_VALUE;
      MODE_ADDR:   p = DATA_W'(a);
      default:     p = '0;
    endcase
    return p;
  endfunction

  // Sweep sequencer: ARM lasts one cycle, CLEAR walks every address once per
  // ce cycle, IDLE hands the bus to the core. start wins from any state and
  // abandons a partial sweep without a done pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= ST_ARM;
      cnt    <= '0;
      mode_q <= 2'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state <= ST_ARM;
        cnt   <= '0;
      end else begin
        case (state)
          ST_ARM: begin
            // Pattern mode is frozen for the whole sweep.
            mode_q <= mode;
            cnt    <= '0;
            state  <= ST_CLEAR;
          end
          ST_CLEAR: begin
            if (ce) begin
              // Wraps to zero on the last location.
              cnt <= cnt + CNT_ONE;
              if (cnt == CNT_LAST) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end
          end
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_ARM;
          end
        endcase
      end
    end
  end

  // RAM port steering: sweep writes while busy, core pass-through in IDLE.
  // Reset forces ARM, so mem_we drops and busy rises without waiting for clk.
  always_comb begin
    mem_ad = '0;
    mem_d  = '0;
    mem_we = 1'b0;
    busy   = 1'b1;
    case (state)
      ST_CLEAR: begin
        mem_ad = cnt;
        mem_d  = pat(mode_q, cnt);
        mem_we = ce;
      end
      ST_IDLE: begin
        mem_ad = cpu_ad;
        mem_d  = cpu_d;
        mem_we = cpu_we & cpu_cs;
        busy   = 1'b0;
      end
      default: begin
        mem_ad = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        busy   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_clear_ctrl.sv
// tb_ram_clear_ctrl: scoreboard bench for ram_clear_ctrl with a 16-entry RAM.
// The stimulus side keeps a list-based model of a sweep (all expected writes
// built up front when a sweep arms) and pushes expected writes and done pulses
// tagged with their cycle; the monitor pops them on mem_we / done.

module tb_ram_clear_ctrl;

  localparam int unsigned AW     = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned STRIPE = 2;
  localparam int unsigned NLOC   = 1 << AW;
  localparam logic [DW-1:0] FILL = 8'hFF;

  localparam int P_ARM   = 0;
  localparam int P_CLEAR = 1;
  localparam int P_IDLE  = 2;

  typedef struct {
    int          cyc;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic          ce;
  logic [AW-1:0] cpu_ad;
  logic [DW-1:0] cpu_d;
  logic          cpu_we;
  logic          cpu_cs;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic          busy;
  logic          done;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  phase  = P_ARM;
  logic exp_busy = 1'b1;

  wr_t exp_wr[$];
  wr_t sweep_q[$];
  int  exp_done[$];

  ram_clear_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .FILL_VALUE(FILL), .STRIPE_LOG2(STRIPE)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .mode(mode), .ce(ce),
    .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
    .mem_ad(mem_ad), .mem_d(mem_d), .mem_we(mem_we), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [1:0] m, input logic [AW-1:0] a);
    case (m)
      2'd0:    return FILL;
      2'd1:    return a[STRIPE] ? ~FILL : FILL;
      2'd2:    return {4'b0000, a};
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: busy every cycle, writes and done pulses against the scoreboard.
  always @(negedge clk_sys) begin
    wr_t w;
    int  dc;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
    end
    if (mem_we !== 1'b0) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL write unexpected cyc=%0d we=%b ad=%h d=%h", cyc, mem_we, mem_ad, mem_d);
      end else begin
        w = exp_wr.pop_front();
        if (mem_we !== 1'b1 || w.cyc != cyc || mem_ad !== w.ad || mem_d !== w.d) begin
          errors++;
          $display("FAIL write cyc=%0d ad=%h d=%h want cyc=%0d ad=%h d=%h",
                   cyc, mem_ad, mem_d, w.cyc, w.ad, w.d);
        end
      end
    end
    if (done !== 1'b0) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done unexpected cyc=%0d got=%b", cyc, done);
      end else begin
        dc = exp_done.pop_front();
        if (done !== 1'b1 || dc != cyc) begin
          errors++;
          $display("FAIL done cyc=%0d got=%b want cyc=%0d", cyc, done, dc);
        end
      end
    end
  end

  // One clock cycle of stimulus plus the model's expectations for it.
  task automatic step(input logic s, input logic [1:0] m, input logic c,
                      input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input logic cw, input logic ccs);
    wr_t w;
    start  = s;
    mode   = m;
    ce     = c;
    cpu_ad = ca;
    cpu_d  = cd;
    cpu_we = cw;
    cpu_cs = ccs;
    exp_busy = (phase != P_IDLE);
    if (phase == P_ARM) begin
      if (!s) begin
        sweep_q.delete();
        for (int a = 0; a < NLOC; a++) begin
          w.cyc = 0;
          w.ad  = AW'(a);
          w.d   = pat(m, AW'(a));
          sweep_q.push_back(w);
        end
        phase = P_CLEAR;
      end
    end else if (phase == P_CLEAR) begin
      if (c) begin
        w = sweep_q.pop_front();
        w.cyc = cyc;
        exp_wr.push_back(w);
        if (sweep_q.size() == 0 && !s) begin
          exp_done.push_back(cyc + 1);
          phase = P_IDLE;
        end
      end
      if (s) begin
        sweep_q.delete();
        phase = P_ARM;
      end
    end else begin
      if (cw && ccs) begin
        w.cyc = cyc;
        w.ad  = ca;
        w.d   = cd;
        exp_wr.push_back(w);
      end
      if (s) phase = P_ARM;
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_now(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    int rel_cyc;
    reset  = 1'b1;
    start  = 1'b0;
    mode   = 2'd0;
    ce     = 1'b0;
    cpu_ad = '0;
    cpu_d  = '0;
    cpu_we = 1'b0;
    cpu_cs = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_now("reset_we", 8'(mem_we), 8'h00);
    check_now("reset_busy", 8'(busy), 8'h01);
    check_now("reset_done", 8'(done), 8'h00);
    check_now("reset_ad", 8'(mem_ad), 8'h00);
    reset = 1'b0;
    phase = P_ARM;
    rel_cyc = cyc;

    // Constant fill with ce high: writes on cycles 1..16, done on 17.
    repeat (NLOC + 2) step(0, 2'd0, 1, '0, '0, 0, 0);
    checks++;
    if (phase != P_IDLE || cyc != rel_cyc + NLOC + 2) begin
      errors++;
      $display("FAIL latency_setup phase=%0d cyc=%0d", phase, cyc);
    end

    // Stripe pattern.
    step(1, 2'd1, 1, '0, '0, 0, 0);
    repeat (NLOC + 2) step(0, 2'd1, 1, '0, '0, 0, 0);

    // Address pattern with ce toggling; mode wiggles and core writes ignored.
    step(1, 2'd2, 0, '0, '0, 0, 0);
    step(0, 2'd2, 0, '0, '0, 0, 0);
    for (int i = 0; i < 2 * NLOC + 4; i++)
      step(0, 2'($urandom_range(0, 3)), (i % 2) == 0, 4'h5, 8'hA5, 1, 1);

    // Abort at cnt=9 with a switch to zero fill.
    step(1, 2'd0, 1, '0, '0, 0, 0);
    step(0, 2'd0, 1, '0, '0, 0, 0);
    while (sweep_q.size() > NLOC - 9) step(0, 2'd0, 1, '0, '0, 0, 0);
    step(1, 2'd3, 1, '0, '0, 0, 0);
    repeat (NLOC + 2) step(0, 2'd3, 1, '0, '0, 0, 0);

    // Core pass-through in IDLE.
    step(0, 2'd0, 0, 4'h5, 8'hA5, 1, 1);
    step(0, 2'd0, 0, 4'h5, 8'hA5, 1, 0);
    step(0, 2'd0, 0, 4'hC, 8'h3C, 1, 1);

    // Asynchronous reset mid-sweep.
    step(1, 2'd2, 1, '0, '0, 0, 0);
    repeat (6) step(0, 2'd2, 1, '0, '0, 0, 0);
    start = 1'b0;
    ce    = 1'b1;
    #2;
    reset = 1'b1;
    exp_busy = 1'b1;
    #1;
    check_now("async_we", 8'(mem_we), 8'h00);
    check_now("async_busy", 8'(busy), 8'h01);
    check_now("async_ad", 8'(mem_ad), 8'h00);
    sweep_q.delete();
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    phase = P_ARM;
    repeat (NLOC + 2) step(0, 2'd2, 1, '0, '0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 59) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, AW'($urandom), DW'($urandom),
           1'($urandom), 1'($urandom));

    // Drain any sweep still in progress.
    for (int i = 0; i < 100 && phase != P_IDLE; i++)
      step(0, 2'd0, 1, '0, '0, 0, 0);
    repeat (3) step(0, 2'd0, 0, '0, '0, 0, 0);

    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got=%0d want=0", exp_wr.size());
    end
    checks++;
    if (exp_done.size() != 0) begin
      errors++;
      $display("FAIL missing_done got=%0d want=0", exp_done.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_clear_ctrl.md
Name: ram_clear_ctrl

Overview:
- Parametrised successor to the inline power-on RAM clear loop in the core top level.
- Sweeps the whole main RAM after reset, or on demand, writing a selectable fill pattern, then hands the RAM bus to the CPU.
- Sits between the machine core's RAM port (ram_ad/ram_d/ram_we/ram_cs) and the block-RAM array in clk_sys.
- Adds three things the inline loop lacks: pattern modes (including DRAM-like stripes), clock-enable pacing, and a busy/done handshake.

Parameters:
- ADDR_W, 16, RAM address width; the sweep covers 2^ADDR_W locations.
- DATA_W, 8, RAM data width.
- FILL_VALUE, all ones (DATA_W bits), base fill value.
- STRIPE_LOG2, 7, address bit that selects stripe polarity in stripe mode; must be < ADDR_W.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  synchronous request to (re)start a clear sweep
- mode  in  2  pattern select: 0 constant, 1 stripe, 2 address low bits, 3 zero
- ce  in  1  sweep advance enable; one write per cycle with ce=1
- cpu_ad  in  ADDR_W  core RAM address
- cpu_d  in  DATA_W  core RAM write data
- cpu_we  in  1  core write enable
- cpu_cs  in  1  core chip select
- mem_ad  out  ADDR_W  RAM array address
- mem_d  out  DATA_W  RAM array write data
- mem_we  out  1  RAM array write strobe, already qualified with chip select
- busy  out  1  high while a sweep is armed or running
- done  out  1  one-cycle pulse when a sweep completes

Behaviour:
- States: ARM, CLEAR, IDLE. Registers: state, cnt[ADDR_W-1:0], mode_q[1:0], done.
- Async reset: state=ARM, cnt=0, mode_q=0, done=0. While reset is high: busy=1, mem_we=0, mem_ad=0.
- ARM (always exactly 1 cycle): mode_q<=mode, cnt<=0, mem_we=0, mem_ad=0, mem_d=0, busy=1. Next state CLEAR.
- CLEAR:
  - mem_ad=cnt, mem_d=pat(mode_q,cnt), mem_we=ce (all combinational from registers), busy=1.
  - If ce=1: cnt<=cnt+1.
  - If ce=1 and cnt is all ones: state<=IDLE, done<=1, cnt wraps to 0.
  - If ce=0: hold, no write.
- IDLE:
  - mem_ad=cpu_ad, mem_d=cpu_d, mem_we=cpu_we&cpu_cs (combinational pass-through), busy=0.
  - done is high only in the first IDLE cycle, then returns to 0.
- pat():
  - mode 0: FILL_VALUE.
  - mode 1: FILL_VALUE when cnt[STRIPE_LOG2]=0, else ~FILL_VALUE.
  - mode 2: cnt zero-extended or truncated to DATA_W.
  - mode 3: 0.
- start=1 in any state (including ARM, CLEAR, or the cycle done is high): next state ARM, done<=0. The sweep restarts from address 0 and any partial sweep is abandoned.
- CPU accesses while busy=1 are dropped: never forwarded, never queued. The core must be held, e.g. by gating its reset with busy.
- mode changes during CLEAR are ignored because mode_q is frozen. mode is sampled only in ARM.
- Latency with ce tied high, counted from reset deassertion (cycle 0 = ARM):
  - writes occur on cycles 1..2^ADDR_W;
  - done=1 and busy=0 on cycle 2^ADDR_W+1.
- Throughput: exactly one write per ce cycle; no skipped or repeated address.
- Reads are not handled here; the RAM read path uses mem_ad directly.

Test Plan:
- ADDR_W=4, DATA_W=8, ce=1, mode=0: release reset -> 16 writes of 0xFF to addr 0..15 on cycles 1..16; done pulse on cycle 17; busy drops on cycle 17.
- ADDR_W=4, STRIPE_LOG2=2, mode=1 -> data sequence FF,FF,FF,FF,00,00,00,00,FF,FF,FF,FF,00,00,00,00.
- mode=2, ce toggling 1,0,1,0 -> exactly one write per ce=1 cycle; data=address 0x00..0x0F; mem_we=0 on ce=0 cycles; done after the 16th write.
- start pulse during CLEAR at cnt=9 with mode changed to 3 -> next cycle ARM (no write), then 16 writes of 0x00 from address 0; no done pulse for the aborted sweep.
- In IDLE: cpu_ad=0x5, cpu_d=0xA5, cpu_we=1, cpu_cs=1 -> mem_we=1, mem_ad=5, mem_d=0xA5 the same cycle. With cpu_cs=0 -> mem_we=0. Same access during CLEAR -> not forwarded.
- Assert reset asynchronously mid-sweep (between clock edges) -> mem_we=0 and busy=1 immediately; after release, a full sweep restarts from address 0.
